// File: rtl/bnn_pkg.sv
// Shared BNN pipeline definitions: unpool FSM states,
// upsample factor and a counter-width helper.
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROW_A = 2'd1,
    ST_ROW_B = 2'd2
  } unpool_state_e;

  localparam int UNPOOL_FACTOR = 2;

  // Never returns less than 1 so single-entry counters still get a bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/unpool_row_buf.sv
// One pooled row of pixels: sync write, async read.
// Storage is deliberately left without reset.
module unpool_row_buf #(
  parameter int WL    = 1,
  parameter int DEPTH = 6,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WL-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WL-1:0] rdata
);

  logic [WL-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/max_unpool_2x.sv
// 2x2 unpooling upsampler: W_IN x H_IN in, 2W_IN x 2H_IN out.
// UNPOOL_ZERO_FILL_EN selects sparse (top-left only) unpooling.
module max_unpool_2x
  import bnn_pkg::*;
#(
  parameter int WL   = 1,
  parameter int W_IN = 6,
  parameter int H_IN = 6
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic [WL-1:0] iDATA,
  input  logic          iVALID,
  output logic          oREADY,
  output logic [WL-1:0] oDATA,
  output logic          oVALID,
  input  logic          iREADY,
  output logic          oEOL,
  output logic          oDONE
);

  localparam int CW = clog2(W_IN);
  localparam int RW = clog2(H_IN);
  localparam int DW = clog2(UNPOOL_FACTOR);

  localparam logic [CW-1:0] COL_LAST =
    CW'(W_IN - 1);
  localparam logic [RW-1:0] ROW_LAST =
    RW'(H_IN - 1);
  localparam logic [DW-1:0] DUP_LAST =
    DW'(UNPOOL_FACTOR - 1);

  unpool_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] dup_q, dup_d;
  logic [WL-1:0] hold_q, hold_d;
  logic          hold_v_q, hold_v_d;
  logic          done_q, done_d;

  logic          out_valid;
  logic          in_ready;
  logic [WL-1:0] out_data;
  logic          out_fire;
  logic          in_fire;
  logic          col_last;
  logic          row_last;
  logic          dup_last;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign dup_last = (dup_q == DUP_LAST);
  assign out_fire = out_valid & iREADY;
  assign in_fire  = iVALID & in_ready;

`ifdef UNPOOL_ZERO_FILL_EN
  always_comb begin
    out_data = '0;
    if (state_q == ST_ROW_A && dup_q == '0)
      out_data = hold_q;
  end
`else
  logic          buf_we;
  logic [CW-1:0] buf_waddr;
  logic [WL-1:0] buf_rdata;

  // A refill lands one slot ahead of the column being drained.
  assign buf_we    = in_fire;
  assign buf_waddr = hold_v_q ? col_q + CW'(1)
                              : col_q;

  unpool_row_buf #(
    .WL    (WL),
    .DEPTH (W_IN),
    .AW    (CW)
  ) u_row_buf (
    .clk   (iCLK),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (iDATA),
    .raddr (col_q),
    .rdata (buf_rdata)
  );

  assign out_data = (state_q == ST_ROW_B)
                  ? buf_rdata : hold_q;
`endif

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      dup_q    <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      dup_q    <= dup_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    dup_d    = dup_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    done_d   = 1'b0;
    if (iSTART) begin
      state_d  = ST_ROW_A;
      col_d    = '0;
      row_d    = '0;
      dup_d    = '0;
      hold_d   = '0;
      hold_v_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ROW_A: begin
          if (out_fire) begin
            dup_d = dup_q + DW'(1);
            if (dup_last) begin
              dup_d    = '0;
              hold_v_d = 1'b0;
              if (col_last) begin
                col_d   = '0;
                state_d = ST_ROW_B;
              end else begin
                col_d = col_q + CW'(1);
              end
            end
          end
          if (in_fire) begin
            hold_d   = iDATA;
            hold_v_d = 1'b1;
          end
        end
        ST_ROW_B: begin
          if (out_fire) begin
            dup_d = dup_q + DW'(1);
            if (dup_last) begin
              dup_d = '0;
              if (col_last) begin
                col_d = '0;
                if (row_last) begin
                  row_d   = '0;
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end else begin
                  row_d   = row_q + RW'(1);
                  state_d = ST_ROW_A;
                end
              end else begin
                col_d = col_q + CW'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // No refill on the row's last pixel: the next
  // pooled row must wait until the replay is done.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      ST_ROW_A: begin
        out_valid = hold_v_q;
        in_ready  = !iSTART &&
                    (!hold_v_q ||
                     (dup_last && iREADY &&
                      !col_last));
      end
      ST_ROW_B: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign oVALID = out_valid;
  assign oREADY = in_ready;
  assign oDATA  = out_valid ? out_data : '0;
  assign oEOL   = out_valid & col_last & dup_last;
  assign oDONE  = done_q;

endmodule

// File: tb/tb_max_unpool_2x.sv
// Self-checking bench for max_unpool_2x: table frame,
// random frames vs. a 2x2 model, stalls, abort, reset.
module tb_max_unpool_2x;

  localparam int WL   = 1;
  localparam int W    = 6;
  localparam int H    = 6;
  localparam int NOUT = 4 * W * H;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iSTART;
  logic [WL-1:0] iDATA;
  logic          iVALID;
  logic          oREADY;
  logic [WL-1:0] oDATA;
  logic          oVALID;
  logic          iREADY;
  logic          oEOL;
  logic          oDONE;

  max_unpool_2x #(
    .WL   (WL),
    .W_IN (W),
    .H_IN (H)
  ) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iSTART (iSTART),
    .iDATA  (iDATA),
    .iVALID (iVALID),
    .oREADY (oREADY),
    .oDATA  (oDATA),
    .oVALID (oVALID),
    .iREADY (iREADY),
    .oEOL   (oEOL),
    .oDONE  (oDONE)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [WL-1:0] d;
    logic          eol;
  } opx_t;

  typedef struct {
    logic [W-1:0]   in_row;
    logic [2*W-1:0] exp_a;
    logic [2*W-1:0] exp_b;
  } vec_t;

  vec_t          tbl [H];
  logic [WL-1:0] in_q [$];
  opx_t          out_q [$];
  logic [WL-1:0] frame [H][W];

  int checks    = 0;
  int failures  = 0;
  int run_done  = 0;
  int done_at   = -1;
  int last_fire = -10;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               name, got, exp);
    end
  endtask

  task automatic start_frame();
    @(posedge iCLK);
    #1;
    iSTART = 1'b1;
    iVALID = 1'b0;
    iREADY = 1'b1;
  endtask

  task automatic load_random();
    for (int r = 0; r < H; r++)
      for (int x = 0; x < W; x++) begin
        frame[r][x] = WL'($urandom);
        in_q.push_back(frame[r][x]);
      end
  endtask

  task automatic reload_frame();
    for (int r = 0; r < H; r++)
      for (int x = 0; x < W; x++)
        in_q.push_back(frame[r][x]);
  endtask

  // Drives inputs, collects output fires, checks
  // acceptance windows, stall stability and oDONE.
  task automatic run(input int exp_n,
                     input int rdy_pct,
                     input int vld_pct,
                     input int abort_at);
    int nfire, nin, budget, lo, hi, k;
    bit stop, stall_pend;
    logic [WL-1:0] sd;
    logic se;
    nfire = 0; nin = 0; stop = 0;
    stall_pend = 0; sd = '0; se = 0;
    run_done = 0; done_at = -1;
    last_fire = -10;
    out_q.delete();
    budget = 8 * exp_n + 50;
    for (int c = 0; c < budget && !stop; c++) begin
      @(posedge iCLK);
      #1;
      iSTART = (abort_at >= 0 && nfire == abort_at);
      iREADY = ($urandom_range(99) < rdy_pct);
      iVALID = (in_q.size() > 0) &&
               ($urandom_range(99) < vld_pct);
      iDATA  = (in_q.size() > 0) ? in_q[0] : '0;
      @(negedge iCLK);
      if (oDONE) begin
        run_done++;
        done_at = c;
      end
      if (iSTART) begin
        stop = 1;
      end else begin
        if (stall_pend) begin
          chk($sformatf("stall_valid_c%0d", c),
              oVALID, 1);
          chk($sformatf("stall_data_c%0d", c),
              oDATA, sd);
          chk($sformatf("stall_eol_c%0d", c),
              oEOL, se);
        end
        stall_pend = oVALID && !iREADY;
        sd = oDATA;
        se = oEOL;
        if (iVALID && oREADY) begin
          k  = nin;
          lo = (k / W) * 4 * W;
          hi = lo + 2 * (k % W);
          if (k % W != 0) lo = hi - 1;
          chk($sformatf("accept_win_px%0d_f%0d",
                        k, nfire),
              (nfire >= lo && nfire <= hi), 1);
          void'(in_q.pop_front());
          nin++;
        end
        if (oVALID && iREADY) begin
          out_q.push_back('{d: oDATA, eol: oEOL});
          nfire++;
          last_fire = c;
        end
        if (nfire == exp_n && c == last_fire + 1)
          stop = 1;
      end
    end
    chk("run_finished", stop, 1);
    @(posedge iCLK);
    #1;
    iSTART = 1'b0;
    iVALID = 1'b0;
    @(negedge iCLK);
    if (oDONE) run_done++;
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done_cnt"}, run_done, 1);
    chk({tag, "_done_at"}, done_at, last_fire + 1);
  endtask

  // Reference: each pooled pixel covers a 2x2 output
  // block; sparse mode keeps only its top-left corner.
  task automatic check_model(input string tag);
    int idx;
    logic [WL-1:0] e;
    chk({tag, "_count"}, out_q.size(), NOUT);
    for (int r = 0; r < H; r++)
      for (int y = 0; y < 2; y++)
        for (int xo = 0; xo < 2 * W; xo++) begin
          idx = (2 * r + y) * 2 * W + xo;
          e = frame[r][xo / 2];
`ifdef UNPOOL_ZERO_FILL_EN
          if (y != 0 || xo % 2 != 0) e = '0;
`endif
          if (idx < out_q.size()) begin
            chk($sformatf("%s_px%0d", tag, idx),
                out_q[idx].d, e);
            chk($sformatf("%s_eol%0d", tag, idx),
                out_q[idx].eol, (xo == 2 * W - 1));
          end
        end
  endtask

  task automatic check_table();
    int idx;
    logic [2*W-1:0] row_v;
    chk("tbl_count", out_q.size(), NOUT);
    for (int r = 0; r < H; r++)
      for (int y = 0; y < 2; y++) begin
        row_v = (y == 0) ? tbl[r].exp_a
                         : tbl[r].exp_b;
        for (int j = 0; j < 2 * W; j++) begin
          idx = (2 * r + y) * 2 * W + j;
          if (idx < out_q.size()) begin
            chk($sformatf("tbl_r%0d_y%0d_px%0d",
                          r, y, j),
                out_q[idx].d, row_v[2*W-1-j]);
            chk($sformatf("tbl_r%0d_y%0d_eol%0d",
                          r, y, j),
                out_q[idx].eol, (j == 2 * W - 1));
          end
        end
      end
  endtask

  initial begin
`ifdef UNPOOL_ZERO_FILL_EN
    tbl[0] = '{6'b101100, 12'b100010100000, 12'b0};
    tbl[1] = '{6'b010011, 12'b001000001010, 12'b0};
    tbl[2] = '{6'b111111, 12'b101010101010, 12'b0};
    tbl[3] = '{6'b000000, 12'b000000000000, 12'b0};
    tbl[4] = '{6'b100001, 12'b100000000010, 12'b0};
    tbl[5] = '{6'b011010, 12'b001010001000, 12'b0};
`else
    tbl[0] = '{6'b101100, 12'b110011110000,
               12'b110011110000};
    tbl[1] = '{6'b010011, 12'b001100001111,
               12'b001100001111};
    tbl[2] = '{6'b111111, 12'b111111111111,
               12'b111111111111};
    tbl[3] = '{6'b000000, 12'b000000000000,
               12'b000000000000};
    tbl[4] = '{6'b100001, 12'b110000000011,
               12'b110000000011};
    tbl[5] = '{6'b011010, 12'b001111001100,
               12'b001111001100};
`endif

    iRST = 1'b0; iSTART = 1'b0; iDATA = '0;
    iVALID = 1'b0; iREADY = 1'b1;
    #3;
    chk("rst_oREADY", oREADY, 0);
    chk("rst_oVALID", oVALID, 0);
    chk("rst_oDATA", oDATA, 0);
    chk("rst_oEOL", oEOL, 0);
    chk("rst_oDONE", oDONE, 0);
    #9;
    iRST = 1'b1;

    // Mid-frame asynchronous reset.
    start_frame();
    for (int i = 0; i < 3; i++) begin
      @(posedge iCLK);
      #1;
      iSTART = 1'b0;
      iVALID = 1'b1;
      iDATA  = '1;
      iREADY = 1'b0;
    end
    @(negedge iCLK);
    chk("pre_rst_valid", oVALID, 1);
    chk("pre_rst_data", oDATA, 1);
    #2;
    iRST = 1'b0;
    #1;
    chk("arst_oREADY", oREADY, 0);
    chk("arst_oVALID", oVALID, 0);
    chk("arst_oDATA", oDATA, 0);
    chk("arst_oEOL", oEOL, 0);
    chk("arst_oDONE", oDONE, 0);
    #1;
    iRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      chk($sformatf("idle_ready%0d", i), oREADY, 0);
      chk($sformatf("idle_valid%0d", i), oVALID, 0);
    end
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;

    // Table frame, full rate.
    start_frame();
    for (int r = 0; r < H; r++)
      for (int x = 0; x < W; x++) begin
        frame[r][x] = WL'(tbl[r].in_row[W-1-x]);
        in_q.push_back(frame[r][x]);
      end
    run(NOUT, 100, 100, -1);
    check_table();
    check_done("tbl");

    // Random frame, full rate.
    start_frame();
    load_random();
    run(NOUT, 100, 100, -1);
    check_model("rnd");
    check_done("rnd");

    // Same frame with random back-pressure and bubbles.
    start_frame();
    reload_frame();
    run(NOUT, 50, 70, -1);
    check_model("bp");
    check_done("bp");

    // Abort at output pixel 30, then a fresh frame.
    start_frame();
    load_random();
    run(NOUT, 100, 100, 30);
    chk("abort_no_done", run_done, 0);
    chk("abort_ready", oREADY, 1);
    chk("abort_valid", oVALID, 0);
    in_q.delete();
    load_random();
    run(NOUT, 80, 90, -1);
    check_model("restart");
    check_done("restart");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
